wb_src_arbiter: RTL and testbench

- Round-robin arbiter for the shared writeback path.
- Up to 8 producers (ALU, load unit, mul/div, CSR, PC+4, etc.) request the single register-file write port.
- The block grants one producer per cycle and drives the 3-bit select of the 8:1 32-bit writeback mux.
- It sits at the EX/MEM -> WB boundary and honours a pipeline stall.

---
 rtl/wb_src_arbiter_if.sv | 26 ++
 rtl/wb_src_arbiter.sv | 87 ++++++++
 tb/tb_wb_src_arbiter.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_src_arbiter_if.sv
// Writeback-source arbitration bundle: producer requests and stall in, registered grant/select out.
interface wb_src_arbiter_if #(
  parameter int unsigned N = 8
) ();
  logic [N-1:0] req;
  logic         stall;
  logic [N-1:0] gnt;
  logic [2:0]   sel;
  logic         wb_valid;

  modport master (
    input  req,
    input  stall,
    output gnt,
    output sel,
    output wb_valid
  );

  modport slave (
    output req,
    output stall,
    input  gnt,
    input  sel,
    input  wb_valid
  );
endinterface

// File: rtl/wb_src_arbiter.sv
// Round-robin arbiter for the single register-file write port; drives the 8:1 writeback mux select.
// Define WB_ARB_FIXED_PRIO_EN to give requester 0 (main ALU) absolute priority over the rotation.
module wb_src_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst,
  wb_src_arbiter_if.master bus
);

  localparam int unsigned SEL_W = 3;

  logic [N-1:0]     gnt_q;
  logic [N-1:0]     gnt_d;
  logic [N-1:0]     elig;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] win_hi;
  logic [SEL_W-1:0] win_lo;
  logic             found_hi;
  logic             found_lo;
  logic             found;
  logic             valid_q;

  // Wrapping search split in two passes: lowest eligible at or above ptr, else lowest overall.
  // This wraps modulo N without any modulo arithmetic on the index.
  always_comb begin
    elig     = bus.req & ~gnt_q;
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (elig[j] && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = SEL_W'(j);
      end
      if (elig[j] && !found_hi && (j >= 32'(ptr_q))) begin
        found_hi = 1'b1;
        win_hi   = SEL_W'(j);
      end
    end
    found = found_lo;
    win   = found_hi ? win_hi : win_lo;
    ptr_d = (32'(win) == N - 1) ? '0 : win + 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
    if (elig[0]) begin
      win   = '0;
      ptr_d = ptr_q;
    end
`endif
  end

  always_comb begin
    gnt_d = '0;
    for (int unsigned j = 0; j < N; j++) begin
      gnt_d[j] = (SEL_W'(j) == win);
    end
  end

  // Stall freezes every register, so a granted result stays on the mux for the whole stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (!bus.stall) begin
      if (found) begin
        gnt_q   <= gnt_d;
        sel_q   <= win;
        valid_q <= 1'b1;
        ptr_q   <= ptr_d;
      end else begin
        gnt_q   <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.wb_valid = valid_q;

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Directed bench for wb_src_arbiter: N=8 instance for most scenarios, N=5 instance for wrap.
module tb_wb_src_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  wb_src_arbiter_if #(.N(8)) bus8 ();
  wb_src_arbiter_if #(.N(5)) bus5 ();

  wb_src_arbiter #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  wb_src_arbiter #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus8.req = 8'h04;
    tick();
    checks++;
    if (bus8.gnt !== 8'h04) begin
      failures++;
      $display("FAIL reset_pregrant gnt got=%h exp=%h", bus8.gnt, 8'h04);
    end
    bus8.req = 8'h00;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus8.gnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_async gnt got=%h exp=%h", bus8.gnt, 8'h00);
    end
    checks++;
    if (bus8.sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_async sel got=%0d exp=%0d", bus8.sel, 0);
    end
    checks++;
    if (bus8.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async wb_valid got=%b exp=%b", bus8.wb_valid, 1'b0);
    end
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (bus8.gnt !== 8'h00 || bus8.wb_valid !== 1'b0 || bus8.sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_idle got gnt=%h sel=%0d v=%b exp gnt=00 sel=0 v=0",
               bus8.gnt, bus8.sel, bus8.wb_valid);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus8.req = 8'h20;
    tick();
    bus8.req = 8'h00;
    checks++;
    if (bus8.gnt !== 8'h20 || bus8.sel !== 3'd5 || bus8.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_grant got gnt=%h sel=%0d v=%b exp gnt=20 sel=5 v=1",
               bus8.gnt, bus8.sel, bus8.wb_valid);
    end
    tick();
    checks++;
    if (bus8.gnt !== 8'h00 || bus8.sel !== 3'd5 || bus8.wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle got gnt=%h sel=%0d v=%b exp gnt=00 sel=5 v=0",
               bus8.gnt, bus8.sel, bus8.wb_valid);
    end
  endtask

  task automatic test_full_load();
    logic [7:0] exp_gnt;
    logic [2:0] exp_sel;
    do_reset();
    bus8.req = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      tick();
      exp_sel = 3'(i % 8);
      exp_gnt = 8'h01 << exp_sel;
      checks++;
      if (bus8.sel !== exp_sel || bus8.gnt !== exp_gnt || bus8.wb_valid !== 1'b1) begin
        failures++;
        $display("FAIL full_load[%0d] got gnt=%h sel=%0d v=%b exp gnt=%h sel=%0d v=1",
                 i, bus8.gnt, bus8.sel, bus8.wb_valid, exp_gnt, exp_sel);
      end
    end
    bus8.req = 8'h00;
    tick();
    checks++;
    if (bus8.wb_valid !== 1'b0 || bus8.gnt !== 8'h00) begin
      failures++;
      $display("FAIL full_load_drain got gnt=%h v=%b exp gnt=00 v=0", bus8.gnt, bus8.wb_valid);
    end
  endtask

  task automatic test_mask();
    logic [7:0] exp_gnt [3];
    logic       exp_v   [3];
    exp_gnt = '{8'h04, 8'h00, 8'h04};
    exp_v   = '{1'b1, 1'b0, 1'b1};
    do_reset();
    bus8.req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus8.gnt !== exp_gnt[i] || bus8.wb_valid !== exp_v[i] || bus8.sel !== 3'd2) begin
        failures++;
        $display("FAIL mask[%0d] got gnt=%h sel=%0d v=%b exp gnt=%h sel=2 v=%b",
                 i, bus8.gnt, bus8.sel, bus8.wb_valid, exp_gnt[i], exp_v[i]);
      end
    end
    bus8.req = 8'h00;
    tick();
  endtask

  task automatic test_wrap_n5();
    logic [2:0] exp_sel [4];
    exp_sel = '{3'd4, 3'd0, 3'd1, 3'd4};
    do_reset();
    bus5.req = 5'b01000;
    tick();
    bus5.req = 5'b00000;
    checks++;
    if (bus5.sel !== 3'd3 || bus5.gnt !== 5'b01000) begin
      failures++;
      $display("FAIL wrap_setup got gnt=%b sel=%0d exp gnt=01000 sel=3", bus5.gnt, bus5.sel);
    end
    tick();
    bus5.req = 5'b10011;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus5.sel !== exp_sel[i] || bus5.gnt !== (5'b00001 << exp_sel[i]) ||
          bus5.wb_valid !== 1'b1) begin
        failures++;
        $display("FAIL wrap_n5[%0d] got gnt=%b sel=%0d v=%b exp sel=%0d v=1",
                 i, bus5.gnt, bus5.sel, bus5.wb_valid, exp_sel[i]);
      end
    end
    bus5.req = 5'b00000;
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    bus8.req = 8'h08;
    tick();
    checks++;
    if (bus8.gnt !== 8'h08 || bus8.sel !== 3'd3) begin
      failures++;
      $display("FAIL stall_setup got gnt=%h sel=%0d exp gnt=08 sel=3", bus8.gnt, bus8.sel);
    end
    bus8.stall = 1'b1;
    bus8.req   = 8'hF0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus8.gnt !== 8'h08 || bus8.sel !== 3'd3 || bus8.wb_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d] got gnt=%h sel=%0d v=%b exp gnt=08 sel=3 v=1",
                 i, bus8.gnt, bus8.sel, bus8.wb_valid);
      end
    end
    bus8.stall = 1'b0;
    tick();
    checks++;
    if (bus8.gnt !== 8'h10 || bus8.sel !== 3'd4 || bus8.wb_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got gnt=%h sel=%0d v=%b exp gnt=10 sel=4 v=1",
               bus8.gnt, bus8.sel, bus8.wb_valid);
    end
    bus8.req = 8'h00;
    tick();
  endtask

`ifdef WB_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    logic [2:0] exp_sel [2];
    do_reset();
    bus8.req = 8'h81;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus8.sel !== ((i % 2 == 0) ? 3'd0 : 3'd7)) begin
        failures++;
        $display("FAIL fixed_prio_alt[%0d] got sel=%0d exp=%0d", i, bus8.sel,
                 (i % 2 == 0) ? 0 : 7);
      end
    end
    do_reset();
    bus8.req = 8'h04;
    tick();
    bus8.req = 8'h00;
    tick();
    // ptr is 3 here; a requester-0 grant must leave it there, so 3 beats 1 next
    exp_sel = '{3'd0, 3'd3};
    bus8.req = 8'h0B;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus8.sel !== exp_sel[i]) begin
        failures++;
        $display("FAIL fixed_prio_ptr[%0d] got sel=%0d exp=%0d", i, bus8.sel, exp_sel[i]);
      end
    end
    bus8.req = 8'h00;
    tick();
  endtask
`endif

  initial begin
    bus8.req   = '0;
    bus8.stall = 1'b0;
    bus5.req   = '0;
    bus5.stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_single();
    test_full_load();
    test_mask();
    test_wrap_n5();
    test_stall();
`ifdef WB_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
